// File: rtl/dm_pkg.sv
// Shared definitions for the DM transfer master: default widths, op codes, FSM encoding.
// CHK_S/CHK_D states are present only when DM_VERIFY_EN is defined.
package dm_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;

    localparam logic OP_FILL = 1'b0;
    localparam logic OP_COPY = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD    = 3'd1,
        ST_WR    = 3'd2,
`ifdef DM_VERIFY_EN
        ST_CHK_S = 3'd3,
        ST_CHK_D = 3'd4,
`endif
        ST_DONE  = 3'd5
    } dm_state_e;

endpackage

// File: rtl/dm_xfer_cnt.sv
// Byte index for the transfer master: synchronous clear/increment, plus a flag
// marking the final byte of the current transfer.
module dm_xfer_cnt
    import dm_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              clr_i,
    input  logic              inc_i,
    input  logic [ADDR_W-1:0] len_i,
    output logic [ADDR_W-1:0] idx_o,
    output logic              last_o
);

    localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

    logic [ADDR_W-1:0] idx_q;
    logic [ADDR_W-1:0] idx_d;

    always_comb begin
        idx_d = idx_q;
        if (clr_i) begin
            idx_d = '0;
        end else if (inc_i) begin
            idx_d = idx_q + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

    assign idx_o  = idx_q;
    assign last_o = (idx_q == (len_i - ONE));

endmodule

// File: rtl/dm_xfer_master.sv
// FILL/COPY transfer engine driving a single-port data memory, one access per cycle.
// Optional DM_VERIFY_EN adds a read-back pass and a sticky err output.
module dm_xfer_master
    import dm_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              start,
    input  logic              op,
    input  logic [ADDR_W-1:0] src,
    input  logic [ADDR_W-1:0] dst,
    input  logic [ADDR_W-1:0] len,
    input  logic [DATA_W-1:0] pattern,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] WriteD,
    output logic              MemRead,
    output logic              MemWrite,
    input  logic [DATA_W-1:0] ReadD
`ifdef DM_VERIFY_EN
    ,
    output logic              err
`endif
);

    localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

    dm_state_e         state_q;
    logic              busy_q;
    logic              done_q;
    logic              rd_q;
    logic              wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] buf_q;
    logic              op_q;
    logic [ADDR_W-1:0] src_q;
    logic [ADDR_W-1:0] dst_q;
    logic [ADDR_W-1:0] len_q;
`ifdef DM_VERIFY_EN
    logic [DATA_W-1:0] pat_q;
    logic              err_q;
`endif

    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] idx_nx;
    logic              last;
    logic              cnt_clr;
    logic              cnt_inc;

    assign idx_nx = idx + ONE;

    always_comb begin
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
        case (state_q)
            ST_IDLE: cnt_clr = start;
            ST_WR: begin
                cnt_inc = !last;
`ifdef DM_VERIFY_EN
                cnt_clr = last;
`endif
            end
`ifdef DM_VERIFY_EN
            ST_CHK_D: cnt_inc = !last;
`endif
            default: ;
        endcase
    end

    dm_xfer_cnt #(.ADDR_W(ADDR_W)) u_cnt (
        .clk    (clk),
        .Reset  (Reset),
        .clr_i  (cnt_clr),
        .inc_i  (cnt_inc),
        .len_i  (len_q),
        .idx_o  (idx),
        .last_o (last)
    );

    // Outputs are loaded together with the state they belong to, so every
    // port reflects the state being entered rather than the one being left.
    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            buf_q   <= '0;
`ifdef DM_VERIFY_EN
            err_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    rd_q   <= 1'b0;
                    wr_q   <= 1'b0;
                    if (start) begin
                        op_q  <= op;
                        src_q <= src;
                        dst_q <= dst;
                        len_q <= len;
`ifdef DM_VERIFY_EN
                        pat_q <= pattern;
                        err_q <= 1'b0;
`endif
                        if (len == '0) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else if (op == OP_COPY) begin
                            state_q <= ST_RD;
                            busy_q  <= 1'b1;
                            rd_q    <= 1'b1;
                            addr_q  <= src;
                        end else begin
                            state_q <= ST_WR;
                            busy_q  <= 1'b1;
                            wr_q    <= 1'b1;
                            addr_q  <= dst;
                            buf_q   <= pattern;
                        end
                    end
                end
                ST_RD: begin
                    state_q <= ST_WR;
                    buf_q   <= ReadD;
                    rd_q    <= 1'b0;
                    wr_q    <= 1'b1;
                    addr_q  <= dst_q + idx;
                end
                ST_WR: begin
                    wr_q <= 1'b0;
                    if (last) begin
`ifdef DM_VERIFY_EN
                        rd_q <= 1'b1;
                        if (op_q == OP_COPY) begin
                            state_q <= ST_CHK_S;
                            addr_q  <= src_q;
                        end else begin
                            state_q <= ST_CHK_D;
                            addr_q  <= dst_q;
                        end
`else
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
`endif
                    end else if (op_q == OP_COPY) begin
                        state_q <= ST_RD;
                        rd_q    <= 1'b1;
                        addr_q  <= src_q + idx_nx;
                    end else begin
                        wr_q    <= 1'b1;
                        addr_q  <= dst_q + idx_nx;
                    end
                end
`ifdef DM_VERIFY_EN
                // Verify pass: CHK_S snapshots the source byte into buf_q,
                // CHK_D compares the destination byte against it (or the pattern).
                ST_CHK_S: begin
                    state_q <= ST_CHK_D;
                    buf_q   <= ReadD;
                    addr_q  <= dst_q + idx;
                end
                ST_CHK_D: begin
                    if (ReadD != ((op_q == OP_COPY) ? buf_q : pat_q)) begin
                        err_q <= 1'b1;
                    end
                    if (last) begin
                        state_q <= ST_DONE;
                        rd_q    <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (op_q == OP_COPY) begin
                        state_q <= ST_CHK_S;
                        addr_q  <= src_q + idx_nx;
                    end else begin
                        addr_q  <= dst_q + idx_nx;
                    end
                end
`endif
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    rd_q    <= 1'b0;
                    wr_q    <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign address  = addr_q;
    assign WriteD   = buf_q;
    assign MemRead  = rd_q;
    assign MemWrite = wr_q;
`ifdef DM_VERIFY_EN
    assign err      = err_q;
`endif

endmodule

// File: tb/tb_dm_xfer_master.sv
// Scoreboard bench for dm_xfer_master: a byte-array reference model predicts every
// DM access, the done latency and the final memory image; a negedge monitor checks them.
module tb_dm_xfer_master;

    localparam logic OPF = 1'b0;
    localparam logic OPC = 1'b1;

    logic       clk = 1'b0;
    logic       Reset;
    logic       start;
    logic       op;
    logic [7:0] src, dst, len, pattern;
    logic       busy, done, MemRead, MemWrite;
    logic [7:0] address, WriteD, ReadD;
`ifdef DM_VERIFY_EN
    logic       err;
`endif

    always #5 clk = ~clk;

    dm_xfer_master #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk      (clk),
        .Reset    (Reset),
        .start    (start),
        .op       (op),
        .src      (src),
        .dst      (dst),
        .len      (len),
        .pattern  (pattern),
        .busy     (busy),
        .done     (done),
        .address  (address),
        .WriteD   (WriteD),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .ReadD    (ReadD)
`ifdef DM_VERIFY_EN
        , .err    (err)
`endif
    );

    // Data memory: combinational read, write on rising edge, optional one-byte corruption.
    logic [7:0] mem [256];
    logic [7:0] load_img [256];
    logic [7:0] ref_mem [256];
    logic       load_req;
    logic       corrupt_en;
    logic [7:0] corrupt_addr;

    assign ReadD = mem[address];

    always @(posedge clk) begin
        if (load_req) begin
            for (int i = 0; i < 256; i++) mem[i] <= load_img[i];
        end else if (MemWrite) begin
            if (corrupt_en && address == corrupt_addr) mem[address] <= WriteD ^ 8'h5A;
            else mem[address] <= WriteD;
        end
    end

    typedef struct { logic [7:0] a; logic [7:0] d; } wr_t;
    typedef struct { int lat; logic e; } dn_t;
    wr_t        wq[$];
    logic [7:0] rq[$];
    dn_t        dq[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor
    always @(negedge clk) begin
        wr_t        w;
        dn_t        dn;
        logic [7:0] ra;
        if (MemRead && MemWrite) begin
            errors++;
            $display("FAIL rw_exclusive: MemRead=1 MemWrite=1 at addr %02h", address);
        end
        if (!busy && (MemRead || MemWrite)) begin
            errors++;
            $display("FAIL idle_access: busy=0 with rd=%0b wr=%0b", MemRead, MemWrite);
        end
        if (MemWrite) begin
            checks++;
            if (wq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: addr %02h data %02h, none required", address, WriteD);
            end else begin
                w = wq.pop_front();
                if (address !== w.a || WriteD !== w.d) begin
                    errors++;
                    $display("FAIL write: got addr %02h data %02h, required addr %02h data %02h",
                             address, WriteD, w.a, w.d);
                end
            end
        end
        if (MemRead) begin
            checks++;
            if (rq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_read: addr %02h, none required", address);
            end else begin
                ra = rq.pop_front();
                if (address !== ra) begin
                    errors++;
                    $display("FAIL read: got addr %02h, required %02h", address, ra);
                end
            end
        end
        if (done) begin
            checks++;
            if (dq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: at cycle %0d", cyc);
            end else begin
                dn = dq.pop_front();
                if ((cyc - start_cyc) != dn.lat || busy !== 1'b0) begin
                    errors++;
                    $display("FAIL done: latency %0d busy %0b, required latency %0d busy 0",
                             cyc - start_cyc, busy, dn.lat);
                end
`ifdef DM_VERIFY_EN
                if (err !== dn.e) begin
                    errors++;
                    $display("FAIL err_at_done: got %0b, required %0b", err, dn.e);
                end
`endif
            end
        end
    end

    // Reference model: byte-by-byte effect of the transfer on a plain array.
    task automatic model_xfer(input logic o, input logic [7:0] s, input logic [7:0] d,
                              input logic [7:0] l, input logic [7:0] p);
        logic [7:0] v, ad, as;
        dn_t        dn;
        dn.e = 1'b0;
        for (int i = 0; i < l; i++) begin
            ad = d + 8'(i);
            as = s + 8'(i);
            if (o == OPC) begin
                rq.push_back(as);
                v = ref_mem[as];
            end else begin
                v = p;
            end
            wq.push_back('{ad, v});
            ref_mem[ad] = (corrupt_en && ad == corrupt_addr) ? (v ^ 8'h5A) : v;
        end
        if (l == 0) dn.lat = 1;
        else dn.lat = (o == OPC) ? 2 * l + 1 : l + 1;
`ifdef DM_VERIFY_EN
        for (int i = 0; i < l; i++) begin
            ad = d + 8'(i);
            as = s + 8'(i);
            if (o == OPC) begin
                rq.push_back(as);
                rq.push_back(ad);
                if (ref_mem[ad] != ref_mem[as]) dn.e = 1'b1;
            end else begin
                rq.push_back(ad);
                if (ref_mem[ad] != p) dn.e = 1'b1;
            end
        end
        if (l != 0) dn.lat = dn.lat + ((o == OPC) ? 2 * l : l);
`endif
        dq.push_back(dn);
    endtask

    task automatic sync_load();
        for (int i = 0; i < 256; i++) load_img[i] = ref_mem[i];
        @(negedge clk);
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
    endtask

    // Issue one transfer; dup re-pulses start with different operands while busy.
    task automatic run_xfer(input logic o, input logic [7:0] s, input logic [7:0] d,
                            input logic [7:0] l, input logic [7:0] p, input bit dup);
        int n;
        model_xfer(o, s, d, l, p);
        @(negedge clk);
        op = o; src = s; dst = d; len = l; pattern = p;
        start = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
        if (dup) begin
            op = ~o; src = s + 8'h33; dst = d + 8'h47; len = l + 8'd2; pattern = ~p;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        n = 0;
        while (!done && n < 600) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL timeout: no done within %0d cycles (op %0b len %0d)", n, o, l);
            wq.delete(); rq.delete(); dq.delete();
        end
        @(negedge clk);
    endtask

    task automatic check_zero(input string nm);
        checks++;
        if ({busy, done, MemRead, MemWrite, address, WriteD} !== 20'h0) begin
            errors++;
            $display("FAIL %s: busy %0b done %0b rd %0b wr %0b addr %02h wd %02h, required all 0",
                     nm, busy, done, MemRead, MemWrite, address, WriteD);
        end
`ifdef DM_VERIFY_EN
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL %s_err: got %0b, required 0", nm, err);
        end
`endif
    endtask

    task automatic check_mem(input string nm, input logic [7:0] a, input logic [7:0] v);
        checks++;
        if (mem[a] !== v) begin
            errors++;
            $display("FAIL %s: mem[%02h] got %02h, required %02h", nm, a, mem[a], v);
        end
    endtask

    task automatic check_empty(input string nm);
        checks++;
        if (wq.size() != 0 || rq.size() != 0 || dq.size() != 0) begin
            errors++;
            $display("FAIL %s: outstanding writes %0d reads %0d dones %0d, required 0 0 0",
                     nm, wq.size(), rq.size(), dq.size());
        end
    endtask

    initial begin
        logic       ro;
        logic [7:0] rs, rd, rl, rp;
        Reset = 1'b1; start = 1'b0; op = 1'b0;
        src = '0; dst = '0; len = '0; pattern = '0;
        corrupt_en = 1'b0; corrupt_addr = '0; load_req = 1'b0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'($urandom);
        sync_load();
        repeat (2) @(negedge clk);
        check_zero("reset_state");
        Reset = 1'b0;

        // Basic FILL, COPY with preloaded source, wrapping FILL, zero-length.
        run_xfer(OPF, 8'h00, 8'h00, 8'd4, 8'h55, 1'b0);
        for (int i = 0; i < 4; i++) check_mem("fill_basic", 8'(i), 8'h55);

        ref_mem[8'h10] = 8'hA1; ref_mem[8'h11] = 8'hB2; ref_mem[8'h12] = 8'hC3;
        sync_load();
        run_xfer(OPC, 8'h10, 8'h20, 8'd3, 8'h00, 1'b0);
        check_mem("copy_basic0", 8'h20, 8'hA1);
        check_mem("copy_basic1", 8'h21, 8'hB2);
        check_mem("copy_basic2", 8'h22, 8'hC3);

        run_xfer(OPF, 8'h00, 8'hFE, 8'd4, 8'h3C, 1'b0);
        check_mem("fill_wrap", 8'h01, 8'h3C);

        run_xfer(OPF, 8'h00, 8'h30, 8'd0, 8'hEE, 1'b0);
        run_xfer(OPC, 8'h40, 8'h50, 8'd0, 8'h00, 1'b0);

        // Overlapping forward copy and a copy whose source wraps.
        run_xfer(OPC, 8'h80, 8'h82, 8'd6, 8'h00, 1'b0);
        run_xfer(OPC, 8'hFD, 8'hA0, 8'd5, 8'h00, 1'b0);

        // Start pulsed while busy must be ignored.
        run_xfer(OPF, 8'h00, 8'h40, 8'd3, 8'h11, 1'b1);
        repeat (8) @(negedge clk);
        check_empty("ignored_start");

        // Reset during the third byte of an 8-byte FILL.
        for (int i = 0; i < 3; i++) begin
            wq.push_back('{8'h60 + 8'(i), 8'hC7});
            ref_mem[8'h60 + 8'(i)] = 8'hC7;
        end
        @(negedge clk);
        op = OPF; dst = 8'h60; len = 8'd8; pattern = 8'hC7; start = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_after_start: got %0b, required 1", busy);
        end
        op = OPC; src = 8'h90; dst = 8'h70; len = 8'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        Reset = 1'b1;
        @(negedge clk);
        check_zero("reset_abort");
        Reset = 1'b0;
        repeat (10) @(negedge clk);
        check_empty("reset_abort_quiet");

        // Randomized transfers.
        for (int t = 0; t < 25; t++) begin
            ro = 1'($urandom);
            rs = 8'($urandom);
            rd = 8'($urandom);
            rl = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom_range(1, 14));
            rp = 8'($urandom);
            run_xfer(ro, rs, rd, rl, rp, (rl >= 2) && ($urandom_range(0, 3) == 0));
        end

`ifdef DM_VERIFY_EN
        // Corrupt one written byte; err must be flagged at done and persist.
        corrupt_addr = 8'hC2;
        corrupt_en = 1'b1;
        run_xfer(OPF, 8'h00, 8'hC0, 8'd5, 8'h9D, 1'b0);
        corrupt_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (err !== 1'b1) begin
                errors++;
                $display("FAIL err_sticky: got %0b, required 1", err);
            end
        end
        run_xfer(OPF, 8'h00, 8'hC0, 8'd5, 8'h9D, 1'b0);
`endif

        repeat (4) @(negedge clk);
        check_empty("final_queues");
        for (int i = 0; i < 256; i++) check_mem("final_image", 8'(i), ref_mem[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
